// File: rtl/character_motion_pkg.sv
// character_motion_pkg
//   Shared encodings and helpers for the character movement controller.
//   - State, direction and pending-request encodings.
//   - Character sprite dimensions, used by the parent when it sizes draw_rect.
//   - Small helpers for request-to-direction mapping and horizontal clamping.
package character_motion_pkg;

  // Controller states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_JUMP = 2'd1;
  localparam logic [1:0] S_FALL = 2'd2;
  localparam logic [1:0] S_DEAD = 2'd3;

  // Jump directions
  localparam logic [1:0] DIR_L = 2'd0;
  localparam logic [1:0] DIR_R = 2'd1;
  localparam logic [1:0] DIR_U = 2'd2;

  // One-deep pending request slot; also used to encode the request decoded in a cycle
  localparam logic [2:0] P_NONE = 3'd0;
  localparam logic [2:0] P_L    = 3'd1;
  localparam logic [2:0] P_R    = 3'd2;
  localparam logic [2:0] P_U    = 3'd3;
  localparam logic [2:0] P_FAIL = 3'd4;

  localparam int CHARACTER_WIDTH  = 40;
  localparam int CHARACTER_HEIGHT = 60;

  // Direction a pending jump request will travel in
  function automatic logic [1:0] pend_dir(input logic [2:0] p);
    case (p)
      P_L:     pend_dir = DIR_L;
      P_R:     pend_dir = DIR_R;
      default: pend_dir = DIR_U;
    endcase
  endfunction

  // Clamp a signed 11-bit x candidate into [lo, hi]; signed compare avoids wrap at 0
  function automatic logic [9:0] clamp_x(input logic signed [10:0] v,
                                         input logic signed [10:0] lo,
                                         input logic signed [10:0] hi);
    logic signed [10:0] r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    clamp_x = r[9:0];
  endfunction

endpackage

// File: rtl/character_motion.sv
// character_motion
//   Computes the on-screen position of the character for left/right/vertical jumps and for
//   the terminal fail fall. Motion advances once per one_ms_tick. Does no drawing.
// Ports:
//   clk, rst         pixel clock, asynchronous active-high reset
//   module_en        low at a clk edge returns the block to its reset values
//   one_ms_tick      single-cycle 1 ms strobe that paces all motion
//   jump_left/right/up, jump_fail   level-sampled requests (fail > left > right > up)
//   xpos, ypos       character position
//   busy             high while jumping or falling
//   landed, fell     one-cycle completion pulses
module character_motion
  import character_motion_pkg::*;
#(
  parameter int X_INIT  = 379,
  parameter int Y_INIT  = 465,
  parameter int JUMP_MS = 40,
  parameter int FALL_MS = 200,
  parameter int STEP_X  = 1,
  parameter int STEP_Y  = 1,
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 759
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       module_en,
  input  logic       one_ms_tick,
  input  logic       jump_left,
  input  logic       jump_right,
  input  logic       jump_up,
  input  logic       jump_fail,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       busy,
  output logic       landed,
  output logic       fell
);

  localparam int TimerMax = (2 * JUMP_MS > FALL_MS) ? 2 * JUMP_MS : FALL_MS;
  localparam int TW       = $clog2(TimerMax) + 1;

  localparam logic [TW-1:0] JumpHalf = TW'(JUMP_MS);
  localparam logic [TW-1:0] JumpLast = TW'(2 * JUMP_MS - 1);
  localparam logic [TW-1:0] FallLast = TW'(FALL_MS - 1);

  logic [1:0]    state_q, state_d;
  logic [1:0]    dir_q, dir_d;
  logic [2:0]    pend_q, pend_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic          landed_q, landed_d;
  logic          fell_q, fell_d;

  logic [2:0]         req;
  logic [2:0]         pend_m;
  logic signed [10:0] x_cand;
  logic [9:0]         x_clamped;
  logic [10:0]        y_sum;
  logic [9:0]         y_down;
  logic [9:0]         y_jump;

  // Decode this cycle's request by priority
  always_comb begin
    req = P_NONE;
    if (jump_fail)       req = P_FAIL;
    else if (jump_left)  req = P_L;
    else if (jump_right) req = P_R;
    else if (jump_up)    req = P_U;
  end

  // Pending slot merged with this cycle's request (only meaningful while jumping)
  always_comb begin
    pend_m = pend_q;
    if (req == P_FAIL) begin
      pend_m = P_FAIL;
    end else if (req != P_NONE && pend_q != P_FAIL) begin
      pend_m = req;
    end
  end

  // Per-tick position candidates
  always_comb begin
    case (dir_q)
      DIR_L:   x_cand = $signed({1'b0, x_q}) - $signed(11'(STEP_X));
      DIR_R:   x_cand = $signed({1'b0, x_q}) + $signed(11'(STEP_X));
      default: x_cand = $signed({1'b0, x_q});
    endcase
    x_clamped = clamp_x(x_cand, $signed(11'(X_MIN)), $signed(11'(X_MAX)));

    // Downward motion saturates at the bottom of the 10-bit range
    y_sum  = {1'b0, y_q} + 11'(STEP_Y);
    y_down = y_sum[10] ? 10'h3ff : y_sum[9:0];
    y_jump = (timer_q < JumpHalf) ? (y_q - 10'(STEP_Y)) : y_down;
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    pend_d   = pend_q;
    timer_d  = timer_q;
    x_d      = x_q;
    y_d      = y_q;
    landed_d = 1'b0;
    fell_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A new request wins over a coincident tick; the tick is not used for motion
        if (req != P_NONE) begin
          state_d = (req == P_FAIL) ? S_FALL : S_JUMP;
          dir_d   = pend_dir(req);
          timer_d = '0;
        end
      end
      S_JUMP: begin
        pend_d = pend_m;
        if (one_ms_tick) begin
          x_d = x_clamped;
          y_d = y_jump;
          if (timer_q == JumpLast) begin
            landed_d = 1'b1;
            timer_d  = '0;
            // Chain straight into the buffered request without passing through idle
            if (pend_m == P_NONE) begin
              state_d = S_IDLE;
            end else begin
              state_d = (pend_m == P_FAIL) ? S_FALL : S_JUMP;
              dir_d   = pend_dir(pend_m);
              pend_d  = P_NONE;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      S_FALL: begin
        if (one_ms_tick) begin
          y_d = y_down;
          if (timer_q == FallLast) begin
            fell_d  = 1'b1;
            state_d = S_DEAD;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      default: ;  // S_DEAD holds until reset or disable
    endcase

    if (!module_en) begin
      state_d  = S_IDLE;
      dir_d    = DIR_U;
      pend_d   = P_NONE;
      timer_d  = '0;
      x_d      = 10'(X_INIT);
      y_d      = 10'(Y_INIT);
      landed_d = 1'b0;
      fell_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dir_q    <= DIR_U;
      pend_q   <= P_NONE;
      timer_q  <= '0;
      x_q      <= 10'(X_INIT);
      y_q      <= 10'(Y_INIT);
      landed_q <= 1'b0;
      fell_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      timer_q  <= timer_d;
      x_q      <= x_d;
      y_q      <= y_d;
      landed_q <= landed_d;
      fell_q   <= fell_d;
    end
  end

  assign xpos   = x_q;
  assign ypos   = y_q;
  assign busy   = (state_q == S_JUMP) || (state_q == S_FALL);
  assign landed = landed_q;
  assign fell   = fell_q;

endmodule

// File: tb/tb_character_motion.sv
// tb_character_motion
//   Scoreboard bench for character_motion with default parameters. A driver issues
//   directed and random stimulus at the falling edge and pushes the expected post-edge
//   outputs from a position/time reference model; a monitor pops and compares after
//   every rising edge.
module tb_character_motion;

  logic       clk;
  logic       rst;
  logic       module_en;
  logic       one_ms_tick;
  logic       jump_left;
  logic       jump_right;
  logic       jump_up;
  logic       jump_fail;
  logic [9:0] xpos;
  logic [9:0] ypos;
  logic       busy;
  logic       landed;
  logic       fell;

  character_motion dut (
    .clk        (clk),
    .rst        (rst),
    .module_en  (module_en),
    .one_ms_tick(one_ms_tick),
    .jump_left  (jump_left),
    .jump_right (jump_right),
    .jump_up    (jump_up),
    .jump_fail  (jump_fail),
    .xpos       (xpos),
    .ypos       (ypos),
    .busy       (busy),
    .landed     (landed),
    .fell       (fell)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit busy;
    bit landed;
    bit fell;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_landed = 0;
  int   n_fell = 0;

  // Reference model: motion is a function of the start point and ticks elapsed.
  // mode: 0 idle, 1 jumping, 2 falling, 3 dead. pend: 0 none, 1 L, 2 R, 3 U, 4 fail.
  int m_mode, m_k, m_x0, m_y0, m_dx, m_x, m_y, m_pend;
  bit m_landed, m_fell;

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_pend = 0; m_dx = 0;
    m_x = 379; m_y = 465; m_x0 = 379; m_y0 = 465;
  endtask

  task automatic model_start(input int p);
    m_mode = (p == 4) ? 2 : 1;
    m_dx   = (p == 1) ? -1 : (p == 2) ? 1 : 0;
    m_k    = 0;
    m_x0   = m_x;
    m_y0   = m_y;
  endtask

  task automatic model_step(input bit t, l, r, u, f, en, rs);
    int req, p;
    exp_t e;
    m_landed = 0;
    m_fell   = 0;
    req = f ? 4 : l ? 1 : r ? 2 : u ? 3 : 0;
    if (rs || !en) begin
      model_reset();
    end else begin
      case (m_mode)
        0: if (req != 0) model_start(req);
        1: begin
          if (req == 4) m_pend = 4;
          else if (req != 0 && m_pend != 4) m_pend = req;
          if (t) begin
            m_k++;
            m_x = clampi(m_x0 + m_dx * m_k, 0, 759);
            m_y = m_y0 - ((m_k < 40) ? m_k : 40) + ((m_k > 40) ? m_k - 40 : 0);
            if (m_k == 80) begin
              m_landed = 1;
              if (m_pend == 0) begin
                m_mode = 0;
              end else begin
                p = m_pend;
                m_pend = 0;
                model_start(p);
              end
            end
          end
        end
        2: if (t) begin
          m_k++;
          m_y = (m_y0 + m_k > 1023) ? 1023 : m_y0 + m_k;
          if (m_k == 200) begin
            m_fell = 1;
            m_mode = 3;
          end
        end
        default: ;
      endcase
    end
    e.x = m_x; e.y = m_y; e.busy = (m_mode == 1 || m_mode == 2);
    e.landed = m_landed; e.fell = m_fell;
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus; async_rst raises rst between edges and checks it acts at once
  task automatic drive(input bit t, l, r, u, f, en, rs, async_rst);
    @(negedge clk);
    one_ms_tick = t; jump_left = l; jump_right = r; jump_up = u; jump_fail = f;
    module_en = en; rst = rs;
    if (async_rst) begin
      #2 rst = 1'b1;
      #1;
      checks++;
      if (xpos != 10'd379 || ypos != 10'd465 || busy !== 1'b0) begin
        errors++;
        $display("FAIL async_reset: got x=%0d y=%0d busy=%0b, want x=379 y=465 busy=0",
                 xpos, ypos, busy);
      end
      model_step(t, l, r, u, f, en, 1'b1);
    end else begin
      model_step(t, l, r, u, f, en, rs);
    end
  endtask

  task automatic idle_cycle(input bit t);
    drive(t, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic tick_run(input int n);
    for (int i = 0; i < n; i++) begin
      idle_cycle(1);
      idle_cycle(0);
    end
  endtask

  // Monitor: compare every presented output against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (landed) n_landed++;
        if (fell) n_fell++;
        if (int'(xpos) != e.x || int'(ypos) != e.y || busy !== e.busy ||
            landed !== e.landed || fell !== e.fell) begin
          errors++;
          $display("FAIL outputs @%0t: got x=%0d y=%0d busy=%0b landed=%0b fell=%0b, want x=%0d y=%0d busy=%0b landed=%0b fell=%0b",
                   $time, xpos, ypos, busy, landed, fell, e.x, e.y, e.busy, e.landed,
                   e.fell);
        end
      end
    end
  end

  initial begin
    int landed_before;
    rst = 1'b1; module_en = 1'b1; one_ms_tick = 1'b0;
    jump_left = 1'b0; jump_right = 1'b0; jump_up = 1'b0; jump_fail = 1'b0;
    model_reset();
    repeat (3) drive(0, 0, 0, 0, 0, 1, 1, 0);

    // Single right jump: 80 ticks, x ends at 459, y back to 465
    drive(0, 0, 1, 0, 0, 1, 0, 0);
    tick_run(85);

    // Right jump with a left request buffered at tick 30: chained, ends at 459
    landed_before = n_landed;
    drive(1, 0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 170; i++) begin
      idle_cycle(1);
      drive(0, i == 30, 0, 0, 0, 1, 0, 0);
    end
    idle_cycle(0);
    checks++;
    if (n_landed - landed_before != 2) begin
      errors++;
      $display("FAIL chained_landings: got %0d landed pulses, want 2", n_landed - landed_before);
    end

    // Repeated right jumps run into the right-hand clamp
    drive(0, 0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 560; i++) begin
      idle_cycle(1);
      drive(0, 0, (i % 80) == 20 && i < 400, 0, 0, 1, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Left jumps run into the left-hand clamp
    drive(0, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 480; i++) begin
      idle_cycle(1);
      drive(0, (i % 80) == 10 && i < 400, 0, 0, 0, 1, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Fail fall to y=665, dead, later jump ignored, then disable
    drive(1, 0, 0, 0, 1, 1, 0, 0);
    tick_run(205);
    drive(1, 0, 1, 0, 0, 1, 0, 0);
    tick_run(3);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Simultaneous left/right/fail enters the fall; disable mid-fall suppresses fell
    drive(0, 1, 1, 0, 1, 1, 0, 0);
    tick_run(50);
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    // Vertical jump, then fail buffered during it chains into a fall
    drive(1, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 300; i++) begin
      idle_cycle(1);
      drive(0, i == 5, i == 6, 0, i == 7, 1, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset between edges in the middle of a jump
    drive(0, 0, 1, 0, 0, 1, 0, 0);
    tick_run(20);
    drive(0, 0, 0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 1, 0, 0);

    // Random traffic
    for (int i = 0; i < 12000; i++) begin
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 59) == 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 999) == 0, $urandom_range(0, 599) != 0,
            $urandom_range(0, 1999) == 0, $urandom_range(0, 2999) == 0);
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
